// File: rtl/spi_xfer_seq.sv
// SPI transfer sequencer: queues host words in a TX FIFO, feeds them one at a time to the
// shift register (latch, then go until tip), and collects each result into an RX FIFO.
module spi_xfer_seq #(
  parameter int unsigned CHAR_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              rx_en_i,
  input  logic              flush_i,
  input  logic              tx_valid_i,
  input  logic [CHAR_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              rx_valid_o,
  output logic [CHAR_W-1:0] rx_data_o,
  input  logic              rx_ready_i,
  output logic [AW:0]       tx_level_o,
  output logic [AW:0]       rx_level_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              latch_o,
  output logic [3:0]        byte_sel_o,
  output logic [CHAR_W-1:0] p_in_o,
  output logic              go_o,
  input  logic              tip_i,
  input  logic [CHAR_W-1:0] p_out_i
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StCapture} state_e;

  localparam logic [AW:0]   FullCnt = DEPTH[AW:0];
  localparam logic [AW-1:0] PtrOne  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CntOne  = {{AW{1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic              latch_q, latch_d, go_q, go_d, done_q, done_d;
  logic [3:0]        byte_sel_q, byte_sel_d;
  logic [CHAR_W-1:0] p_in_q, p_in_d;
  logic              cap_en_q, cap_en_d, discard_q, discard_d;

  logic [CHAR_W-1:0] tx_mem_q [DEPTH];
  logic [CHAR_W-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0]     tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [AW:0]       tx_cnt_q, rx_cnt_q;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop, start;

  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullCnt);
  assign rx_empty = (rx_cnt_q == '0);

  // Starting only with a free RX slot reserved means a capture can never overflow.
  assign start   = (state_q == StIdle) && en_i && !tx_empty && !flush_i && (!rx_en_i || !rx_full);
  assign tx_push = tx_valid_i && !tx_full && !flush_i;
  assign tx_pop  = start;
  assign rx_pop  = rx_ready_i && !rx_empty && !flush_i;

  always_comb begin
    state_d    = state_q;
    latch_d    = 1'b0;
    byte_sel_d = 4'h0;
    p_in_d     = p_in_q;
    go_d       = 1'b0;
    done_d     = 1'b0;
    cap_en_d   = cap_en_q;
    discard_d  = discard_q;
    rx_push    = 1'b0;
    // A flush cannot abort the shift register, so the in-flight result is dropped instead.
    if (flush_i && (state_q != StIdle) && (state_q != StCapture)) discard_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          latch_d    = 1'b1;
          byte_sel_d = 4'hF;
          p_in_d     = tx_mem_q[tx_rd_q];
          cap_en_d   = rx_en_i;
        end
      end
      StLoad: begin
        state_d = StStart;
        go_d    = 1'b1;
      end
      StStart: begin
        if (tip_i) state_d = StRun;
        else       go_d    = 1'b1;
      end
      StRun: begin
        if (!tip_i) begin
          state_d = StCapture;
          done_d  = 1'b1;
        end
      end
      StCapture: begin
        rx_push   = cap_en_q && !discard_q && !flush_i && !rx_full;
        discard_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      latch_q    <= 1'b0;
      byte_sel_q <= 4'h0;
      p_in_q     <= '0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
      cap_en_q   <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      latch_q    <= latch_d;
      byte_sel_q <= byte_sel_d;
      p_in_q     <= p_in_d;
      go_q       <= go_d;
      done_q     <= done_d;
      cap_en_q   <= cap_en_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else if (flush_i) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PtrOne;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrOne;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CntOne;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CntOne;
      if (rx_push) rx_wr_q <= rx_wr_q + PtrOne;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrOne;
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CntOne;
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data_i;
    if (rx_push) rx_mem_q[rx_wr_q] <= p_out_i;
  end

  assign tx_ready_o = !tx_full;
  assign rx_valid_o = !rx_empty;
  assign rx_data_o  = rx_mem_q[rx_rd_q];
  assign tx_level_o = tx_cnt_q;
  assign rx_level_o = rx_cnt_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign latch_o    = latch_q;
  assign byte_sel_o = byte_sel_q;
  assign p_in_o     = p_in_q;
  assign go_o       = go_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq with a small behavioural shift-register model answering go.
module tb_spi_xfer_seq;
  localparam int CW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0, rst_ni = 1'b0;
  logic          en_i = 1'b0, rx_en_i = 1'b0, flush_i = 1'b0;
  logic          tx_valid_i = 1'b0, rx_ready_i = 1'b0;
  logic [CW-1:0] tx_data_i = '0;
  logic          tx_ready_o, rx_valid_o, busy_o, done_o, latch_o, go_o;
  logic [CW-1:0] rx_data_o, p_in_o;
  logic [AW:0]   tx_level_o, rx_level_o;
  logic [3:0]    byte_sel_o;
  logic          tip_i;
  logic [CW-1:0] p_out_i;

  int checks = 0, errors = 0;
  int latch_cnt = 0, go_cnt = 0, done_cnt = 0, latch_tip_viol = 0;
  logic [CW-1:0] latched_q[$];
  logic go_prev = 1'b0;

  spi_xfer_seq #(.CHAR_W(CW), .DEPTH(8), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .rx_en_i(rx_en_i), .flush_i(flush_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .tx_level_o(tx_level_o), .rx_level_o(rx_level_o), .busy_o(busy_o), .done_o(done_o),
    .latch_o(latch_o), .byte_sel_o(byte_sel_o), .p_in_o(p_in_o), .go_o(go_o),
    .tip_i(tip_i), .p_out_i(p_out_i)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] resp(input logic [CW-1:0] w);
    return (w == 32'hA5A5_1234) ? 32'h0F0F_F0F0 : ~w;
  endfunction

  // Shift-register model: tip rises the cycle after go is seen, stays 4 cycles, then p_out updates.
  logic [CW-1:0] sr_word;
  int sr_cnt;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tip_i <= 1'b0; sr_cnt <= 0; p_out_i <= '0; sr_word <= '0;
    end else begin
      if (latch_o) sr_word <= p_in_o;
      if (!tip_i && go_o && sr_cnt == 0) begin
        tip_i <= 1'b1; sr_cnt <= 4;
      end else if (tip_i) begin
        if (sr_cnt == 1) begin
          tip_i <= 1'b0; p_out_i <= resp(sr_word);
        end
        sr_cnt <= sr_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_ni) begin
      if (latch_o) begin
        latch_cnt++;
        latched_q.push_back(p_in_o);
        if (tip_i) latch_tip_viol++;
      end
      if (go_o && !go_prev) go_cnt++;
      if (done_o) done_cnt++;
      go_prev = go_o;
    end else go_prev = 1'b0;
  end

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_run(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tip_i && !go_o && busy_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_word(input logic [CW-1:0] w);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL push_wait: tx_ready_o=%b, required 1", tx_ready_o); end
    tx_valid_i = 1'b1; tx_data_i = w;
    @(negedge clk);
    tx_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_ready_o, rx_valid_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: ready/valid/busy=%b, required 100", {tx_ready_o, rx_valid_o, busy_o});
    end
    checks++;
    if ({tx_level_o, rx_level_o} !== '0) begin
      errors++; $display("FAIL reset_levels: tx=%0d rx=%0d, required 0 0", tx_level_o, rx_level_o);
    end
    checks++;
    if ({latch_o, go_o, done_o, byte_sel_o, p_in_o} !== '0) begin
      errors++; $display("FAIL reset_outs: latch=%b go=%b done=%b bs=%h p_in=%h, required all 0",
                         latch_o, go_o, done_o, byte_sel_o, p_in_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_single;
    int d0;
    bit ok;
    en_i = 1'b1; rx_en_i = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    tx_valid_i = 1'b1; tx_data_i = 32'hA5A5_1234;
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (tx_level_o !== 4'd1 || latch_o !== 1'b0) begin
      errors++; $display("FAIL single_queued: level=%0d latch=%b, required 1 0", tx_level_o, latch_o);
    end
    @(negedge clk);
    checks++;
    if (latch_o !== 1'b1 || p_in_o !== 32'hA5A5_1234 || byte_sel_o !== 4'hF) begin
      errors++; $display("FAIL single_latch: latch=%b p_in=%h bs=%h, required 1 a5a51234 f",
                         latch_o, p_in_o, byte_sel_o);
    end
    @(negedge clk);
    checks++;
    if (go_o !== 1'b1 || latch_o !== 1'b0 || byte_sel_o !== 4'h0) begin
      errors++; $display("FAIL single_go: go=%b latch=%b bs=%h, required 1 0 0", go_o, latch_o, byte_sel_o);
    end
    wait_done(d0 + 1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_wait: done_cnt=%0d, required %0d", done_cnt, d0 + 1); end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || rx_data_o !== 32'h0F0F_F0F0 || rx_level_o !== 4'd1) begin
      errors++; $display("FAIL single_rx: done=%b data=%h level=%0d, required 0 0f0ff0f0 1",
                         done_o, rx_data_o, rx_level_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL single_done_count: %0d, required 1", done_cnt - d0);
    end
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    checks++;
    if (rx_level_o !== 4'd0) begin errors++; $display("FAIL single_pop: level=%0d, required 0", rx_level_o); end
  endtask

  task automatic test_back_to_back;
    logic [CW-1:0] w[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    int d0, l0, seen;
    bit ok;
    en_i = 1'b0; rx_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_valid_i = 1'b1; tx_data_i = w[i];
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (tx_level_o !== 4'd3) begin errors++; $display("FAIL burst_level3: %0d, required 3", tx_level_o); end
    d0 = done_cnt; l0 = latched_q.size(); seen = 0;
    en_i = 1'b1;
    for (int c = 0; c < 100 && seen < 3; c++) begin
      @(negedge clk);
      if (latch_o) begin
        checks++;
        if (tx_level_o !== 4'(2 - seen)) begin
          errors++; $display("FAIL burst_level_step: %0d, required %0d", tx_level_o, 2 - seen);
        end
        seen++;
      end
    end
    wait_done(d0 + 3, 100, ok);
    checks++;
    if (!ok || seen != 3) begin
      errors++; $display("FAIL burst_wait: dones=%0d latches=%0d, required 3 3", done_cnt - d0, seen);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (latched_q.size() < l0 + 3 || latched_q[l0 + i] !== w[i]) begin
        errors++; $display("FAIL burst_latch_order: idx %0d, required %h", i, w[i]);
      end
      checks++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== resp(w[i])) begin
        errors++; $display("FAIL burst_rx: valid=%b data=%h, required 1 %h", rx_valid_o, rx_data_o, resp(w[i]));
      end
      rx_ready_i = 1'b1;
      @(negedge clk);
    end
    rx_ready_i = 1'b0;
    checks++;
    if (rx_level_o !== 4'd0 || latch_tip_viol !== 0) begin
      errors++; $display("FAIL burst_end: rx_level=%0d latch_during_tip=%0d, required 0 0", rx_level_o, latch_tip_viol);
    end
  endtask

  task automatic test_rx_stall;
    int d0;
    bit ok;
    en_i = 1'b1; rx_en_i = 1'b1; rx_ready_i = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) push_word(32'h1000_0000 + i);
    wait_done(d0 + 8, 300, ok);
    repeat (30) @(negedge clk);
    checks++;
    if (!ok || busy_o !== 1'b0 || tx_level_o !== 4'd2 || rx_level_o !== 4'd8 || done_cnt - d0 !== 8) begin
      errors++; $display("FAIL stall_state: busy=%b tx=%0d rx=%0d dones=%0d, required 0 2 8 8",
                         busy_o, tx_level_o, rx_level_o, done_cnt - d0);
    end
    checks++;
    if (rx_data_o !== resp(32'h1000_0000)) begin
      errors++; $display("FAIL stall_head: %h, required %h", rx_data_o, resp(32'h1000_0000));
    end
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 9 || tx_level_o !== 4'd1 || rx_level_o !== 4'd8 || busy_o !== 1'b0) begin
      errors++; $display("FAIL stall_one_more: dones=%0d tx=%0d rx=%0d busy=%b, required 9 1 8 0",
                         done_cnt - d0, tx_level_o, rx_level_o, busy_o);
    end
    en_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if (tx_level_o !== 4'd0 || rx_level_o !== 4'd0) begin
      errors++; $display("FAIL stall_flush_idle: tx=%0d rx=%0d, required 0 0", tx_level_o, rx_level_o);
    end
  endtask

  task automatic test_flush;
    int d0, g1;
    bit ok;
    en_i = 1'b0; rx_en_i = 1'b1;
    for (int i = 0; i < 5; i++) push_word(32'h2000_0000 + i);
    d0 = done_cnt;
    en_i = 1'b1;
    wait_run(40, ok);
    checks++;
    if (!ok || tx_level_o !== 4'd4) begin
      errors++; $display("FAIL flush_run: in_run=%b tx=%0d, required 1 4", ok, tx_level_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    g1 = go_cnt;
    checks++;
    if (tx_level_o !== 4'd0 || rx_level_o !== 4'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_levels: tx=%0d rx=%0d busy=%b, required 0 0 1", tx_level_o, rx_level_o, busy_o);
    end
    wait_done(d0 + 1, 40, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || done_cnt - d0 !== 1 || rx_level_o !== 4'd0 || go_cnt !== g1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_after: dones=%0d rx=%0d new_go=%0d busy=%b, required 1 0 0 0",
                         done_cnt - d0, rx_level_o, go_cnt - g1, busy_o);
    end
  endtask

  task automatic test_fifo_bounds;
    logic [CW-1:0] exp_q[$];
    en_i = 1'b0; rx_en_i = 1'b1; rx_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tx_valid_i = 1'b1; tx_data_i = 32'hB000_0000 + i;
      if (i < 8) exp_q.push_back(32'hB000_0000 + i);
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
    checks++;
    if (tx_level_o !== 4'd8 || tx_ready_o !== 1'b0) begin
      errors++; $display("FAIL bounds_full: level=%0d ready=%b, required 8 0", tx_level_o, tx_ready_o);
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(32'hC000_0000 + i);
    rx_ready_i = 1'b1; en_i = 1'b1;
    fork
      for (int i = 0; i < 12; i++) push_word(32'hC000_0000 + i);
      for (int k = 0; k < 20; k++) begin
        bit got = 1'b0;
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (rx_valid_o) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || rx_data_o !== resp(exp_q[k])) begin
          errors++; $display("FAIL bounds_data: item %0d got=%b data=%h, required %h", k, got, rx_data_o, resp(exp_q[k]));
        end
      end
    join
    repeat (20) @(negedge clk);
    rx_ready_i = 1'b0;
    checks++;
    if (tx_level_o !== 4'd0 || rx_level_o !== 4'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL bounds_drained: tx=%0d rx=%0d busy=%b, required 0 0 0", tx_level_o, rx_level_o, busy_o);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    en_i = 1'b1; rx_en_i = 1'b1;
    push_word(32'hD000_0001);
    push_word(32'hD000_0002);
    wait_run(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_run: reached_run=%b, required 1", ok); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, go_o, latch_o, done_o, byte_sel_o} !== '0 || p_in_o !== '0) begin
      errors++; $display("FAIL rstmid_outs: busy=%b go=%b latch=%b done=%b bs=%h p_in=%h, required all 0",
                         busy_o, go_o, latch_o, done_o, byte_sel_o, p_in_o);
    end
    checks++;
    if (tx_level_o !== 4'd0 || rx_level_o !== 4'd0 || tx_ready_o !== 1'b1 || rx_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_fifo: tx=%0d rx=%0d ready=%b valid=%b, required 0 0 1 0",
                         tx_level_o, rx_level_o, tx_ready_o, rx_valid_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || latch_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: busy=%b latch=%b, required 0 0", busy_o, latch_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rx_stall();
    test_flush();
    test_fifo_bounds();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
